// File: rtl/vend_pkg.sv
// vend_pkg: shared states, selection bit indices, default prices and coin values
package vend_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_CHECK, S_SETUP, S_DEDUCT, S_HOLD, S_DISPENSE, S_DENY, S_CHANGE, S_GAP, S_CLEAR
   } state_t;
   localparam int CANDY   = 3;
   localparam int COOKIES = 2;
   localparam int CHIPS   = 1;
   localparam int GUM     = 0;
   localparam logic [7:0] PRICE_CANDY_DEF   = 8'd75;
   localparam logic [7:0] PRICE_COOKIES_DEF = 8'd65;
   localparam logic [7:0] PRICE_CHIPS_DEF   = 8'd85;
   localparam logic [7:0] PRICE_GUM_DEF     = 8'd50;
   localparam logic [7:0] QUARTER = 8'd25;
   localparam logic [7:0] DIME    = 8'd10;
   localparam logic [7:0] NICKEL  = 8'd5;
endpackage

// File: rtl/vend_ctrl_if.sv
// vend_ctrl_if: balance/selection inputs and item/strobe/change outputs of the vending controller
//   master drives coins/sel/sel_valid/refund; slave (the controller) drives everything else
interface vend_ctrl_if;
   logic [7:0] coins;
   logic [3:0] sel;
   logic       sel_valid;
   logic       refund;
   logic [3:0] item;
   logic       sub;
   logic       clr;
   logic       dispense;
   logic       deny;
   logic       nickel_out;
   logic       dime_out;
   logic       quarter_out;
   logic       busy;
   modport master (
      output coins, sel, sel_valid, refund,
      input  item, sub, clr, dispense, deny, nickel_out, dime_out, quarter_out, busy
   );
   modport slave (
      input  coins, sel, sel_valid, refund,
      output item, sub, clr, dispense, deny, nickel_out, dime_out, quarter_out, busy
   );
endinterface

// File: rtl/vend_ctrl_change_dispenser.sv
// change_dispenser: greedy coin-by-coin payout of a latched amount, then one clr pulse
//   start_i/amount_i latch the balance; done_o is high in the clearing cycle;
//   nickel_o/dime_o/quarter_o/clr_o are registered one-cycle pulses
module change_dispenser
   import vend_pkg::*;
#(
   parameter int COIN_GAP = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start_i,
   input  logic [7:0] amount_i,
   output logic       done_o,
   output logic       nickel_o,
   output logic       dime_o,
   output logic       quarter_o,
   output logic       clr_o
);
   localparam logic [7:0] GAP_INIT = (COIN_GAP == 0) ? 8'd0 : 8'(COIN_GAP - 1);
   state_t     phase_q, phase_d;
   logic [7:0] rem_q, rem_d, gap_q, gap_d;
   logic [2:0] coin_q, coin_d;
   logic       clr_q, clr_d;
   always_comb begin
      phase_d = phase_q;
      rem_d   = rem_q;
      gap_d   = gap_q;
      coin_d  = 3'b000;
      clr_d   = 1'b0;
      case (phase_q)
         S_IDLE: if (start_i) begin
            rem_d   = amount_i;
            phase_d = S_CHANGE;
         end
         S_CHANGE: begin
            if (rem_q >= QUARTER) begin
               coin_d = 3'b100;
               rem_d  = rem_q - QUARTER;
            end else if (rem_q >= DIME) begin
               coin_d = 3'b010;
               rem_d  = rem_q - DIME;
            end else if (rem_q >= NICKEL) begin
               coin_d = 3'b001;
               rem_d  = rem_q - NICKEL;
            end else begin
               rem_d   = 8'd0;
               phase_d = S_CLEAR;
            end
            // with a zero gap the next coin is chosen on the very next cycle
            if (coin_d != 3'b000 && COIN_GAP != 0) begin
               phase_d = S_GAP;
               gap_d   = GAP_INIT;
            end
         end
         S_GAP: begin
            phase_d = (gap_q == 8'd0) ? S_CHANGE : S_GAP;
            gap_d   = (gap_q == 8'd0) ? 8'd0 : gap_q - 8'd1;
         end
         S_CLEAR: begin
            clr_d   = 1'b1;
            phase_d = S_IDLE;
         end
         default: phase_d = S_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_q <= S_IDLE;
         rem_q   <= 8'd0;
         gap_q   <= 8'd0;
         coin_q  <= 3'b000;
         clr_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         rem_q   <= rem_d;
         gap_q   <= gap_d;
         coin_q  <= coin_d;
         clr_q   <= clr_d;
      end
   end
   assign done_o    = (phase_q == S_CLEAR);
   assign quarter_o = coin_q[2];
   assign dime_o    = coin_q[1];
   assign nickel_o  = coin_q[0];
   assign clr_o     = clr_q;
endmodule

// File: rtl/vend_ctrl.sv
// vend_ctrl: vending controller - funds check, debit strobes, timed dispense, change payout
//   clk/reset (async, active-high); bus is the slave side of vend_ctrl_if
module vend_ctrl
   import vend_pkg::*;
#(
   parameter logic [7:0] PRICE_CANDY   = PRICE_CANDY_DEF,
   parameter logic [7:0] PRICE_COOKIES = PRICE_COOKIES_DEF,
   parameter logic [7:0] PRICE_CHIPS   = PRICE_CHIPS_DEF,
   parameter logic [7:0] PRICE_GUM     = PRICE_GUM_DEF,
   parameter int         DISP_CYCLES   = 4,
   parameter int         COIN_GAP      = 2
) (
   input logic        clk,
   input logic        reset,
   vend_ctrl_if.slave bus
);
   localparam logic [7:0] DISP_INIT = 8'(DISP_CYCLES - 1);
   state_t     state_q, state_d;
   logic [3:0] sel_q, sel_d, item_q, item_d;
   logic [7:0] price_q, price_d, cnt_q, cnt_d;
   logic       sub_q, sub_d, dispense_q, dispense_d, deny_q, deny_d, busy_q, busy_d;
   logic       start, done;
   always_comb begin
      state_d = state_q;
      sel_d   = sel_q;
      price_d = price_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      case (state_q)
         S_IDLE: if (bus.refund) begin
            start   = 1'b1;
            state_d = S_CHANGE;
         end else if (bus.sel_valid) begin
            state_d = $onehot(bus.sel) ? S_CHECK : S_DENY;
            sel_d   = bus.sel;
            price_d = bus.sel[CANDY]   ? PRICE_CANDY :
                      bus.sel[COOKIES] ? PRICE_COOKIES :
                      bus.sel[CHIPS]   ? PRICE_CHIPS : PRICE_GUM;
         end
         S_CHECK:  state_d = (bus.coins >= price_q) ? S_SETUP : S_DENY;
         S_SETUP:  state_d = S_DEDUCT;
         S_DEDUCT: state_d = S_HOLD;
         S_HOLD: begin
            state_d = S_DISPENSE;
            cnt_d   = DISP_INIT;
         end
         S_DISPENSE: begin
            state_d = (cnt_q == 8'd0) ? S_IDLE : S_DISPENSE;
            cnt_d   = (cnt_q == 8'd0) ? 8'd0 : cnt_q - 8'd1;
         end
         S_CHANGE: state_d = done ? S_IDLE : S_CHANGE;
         default:  state_d = S_IDLE;
      endcase
   end
   // outputs decode the current state and register it, so each state shows one cycle later
   always_comb begin
      item_d     = (state_q inside {S_SETUP, S_DEDUCT, S_HOLD, S_DISPENSE}) ? sel_q : 4'b0000;
      sub_d      = (state_q == S_DEDUCT);
      dispense_d = (state_q == S_DISPENSE);
      deny_d     = (state_q == S_DENY);
      busy_d     = (state_q != S_IDLE);
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         sel_q      <= 4'b0000;
         price_q    <= 8'd0;
         cnt_q      <= 8'd0;
         item_q     <= 4'b0000;
         sub_q      <= 1'b0;
         dispense_q <= 1'b0;
         deny_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         price_q    <= price_d;
         cnt_q      <= cnt_d;
         item_q     <= item_d;
         sub_q      <= sub_d;
         dispense_q <= dispense_d;
         deny_q     <= deny_d;
         busy_q     <= busy_d;
      end
   end
   change_dispenser #(.COIN_GAP(COIN_GAP)) u_change (
      .clk       (clk),
      .reset     (reset),
      .start_i   (start),
      .amount_i  (bus.coins),
      .done_o    (done),
      .nickel_o  (bus.nickel_out),
      .dime_o    (bus.dime_out),
      .quarter_o (bus.quarter_out),
      .clr_o     (bus.clr)
   );
   assign bus.item     = item_q;
   assign bus.sub      = sub_q;
   assign bus.dispense = dispense_q;
   assign bus.deny     = deny_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_vend_ctrl.sv
// tb_vend_ctrl: scoreboard bench for vend_ctrl, per-cycle expected output vectors
module tb_vend_ctrl;
   localparam int G = 2;
   localparam int DISP = 4;
   // packed view: {item[3:0], sub, clr, dispense, deny, quarter, dime, nickel, busy}
   localparam logic [11:0] BZ = 12'h001, NK = 12'h002, DM = 12'h004, QT = 12'h008;
   localparam logic [11:0] DN = 12'h010, CL = 12'h040;
   logic clk = 1'b0;
   logic reset = 1'b1;
   vend_ctrl_if bus();
   vend_ctrl dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   logic [11:0] exp_q[$];
   logic [11:0] e;
   int errors = 0;
   int checks = 0;
   function automatic logic [11:0] outs();
      return {bus.item, bus.sub, bus.clr, bus.dispense, bus.deny,
              bus.quarter_out, bus.dime_out, bus.nickel_out, bus.busy};
   endfunction
   task automatic push_vend(input logic [3:0] s);
      exp_q.push_back(12'h000);
      exp_q.push_back(BZ);
      exp_q.push_back({s, 8'h01});
      exp_q.push_back({s, 8'h81});
      exp_q.push_back({s, 8'h01});
      for (int i = 0; i < DISP; i++) exp_q.push_back({s, 8'h21});
      exp_q.push_back(12'h000);
   endtask
   task automatic push_deny_funds();
      exp_q.push_back(12'h000);
      exp_q.push_back(BZ);
      exp_q.push_back(DN | BZ);
      exp_q.push_back(12'h000);
   endtask
   task automatic push_refund(input int amount);
      int rem;
      rem = amount;
      exp_q.push_back(12'h000);
      while (rem >= 5) begin
         if (rem >= 25) begin exp_q.push_back(QT | BZ); rem -= 25; end
         else if (rem >= 10) begin exp_q.push_back(DM | BZ); rem -= 10; end
         else begin exp_q.push_back(NK | BZ); rem -= 5; end
         for (int i = 0; i < G; i++) exp_q.push_back(BZ);
      end
      exp_q.push_back(BZ);
      exp_q.push_back(CL | BZ);
      exp_q.push_back(12'h000);
   endtask
   task automatic test_reset();
      int n = 0;
      repeat (2) @(negedge clk);
      checks++;
      if (outs() !== 12'h000) begin errors++; $display("FAIL reset_hold got=%h want=000", outs()); end
      reset = 1'b0;
      repeat (3) exp_q.push_back(12'h000);
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL reset_idle cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   task automatic test_vend_candy();
      int n = 0;
      push_vend(4'b1000);
      bus.coins = 8'd100; bus.sel = 4'b1000; bus.sel_valid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL vend_candy cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   task automatic test_deny_funds();
      int n = 0;
      push_deny_funds();
      bus.coins = 8'd60; bus.sel = 4'b0010; bus.sel_valid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL deny_funds cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   task automatic test_deny_multihot();
      int n = 0;
      exp_q.push_back(12'h000);
      exp_q.push_back(DN | BZ);
      exp_q.push_back(12'h000);
      bus.coins = 8'd200; bus.sel = 4'b0110; bus.sel_valid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL deny_multihot cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   task automatic test_back_to_back();
      int n = 0;
      // exact price vends, one cent short is refused, back to back
      push_vend(4'b0100);
      bus.coins = 8'd65; bus.sel = 4'b0100; bus.sel_valid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL exact_price cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
      push_deny_funds();
      bus.coins = 8'd64; bus.sel_valid = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL short_cent cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   task automatic test_refund(input int amount, input logic with_sel);
      int n = 0;
      push_refund(amount);
      bus.coins = 8'(amount); bus.sel = 4'b1000; bus.sel_valid = with_sel; bus.refund = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0; bus.refund = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin
            errors++;
            $display("FAIL refund_%0d sel=%b cyc%0d got=%h want=%h", amount, with_sel, n, outs(), e);
         end
         n++;
      end
   endtask
   task automatic test_reset_mid();
      int n = 0;
      exp_q.push_back(12'h000);
      exp_q.push_back(QT | BZ);
      bus.coins = 8'd90; bus.refund = 1'b1;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.refund = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL mid_first_quarter cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
      #1 reset = 1'b1;
      #1 checks++;
      if (outs() !== 12'h000) begin errors++; $display("FAIL mid_async_reset got=%h want=000", outs()); end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (10) exp_q.push_back(12'h000);
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL mid_quiet cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
      push_vend(4'b0001);
      bus.coins = 8'd50; bus.sel = 4'b0001; bus.sel_valid = 1'b1;
      n = 0;
      while (exp_q.size() > 0) begin
         @(negedge clk); bus.sel_valid = 1'b0;
         e = exp_q.pop_front(); checks++;
         if (outs() !== e) begin errors++; $display("FAIL mid_next_vend cyc%0d got=%h want=%h", n, outs(), e); end
         n++;
      end
   endtask
   initial begin
      bus.coins = 8'd0; bus.sel = 4'b0000; bus.sel_valid = 1'b0; bus.refund = 1'b0;
      test_reset();
      test_vend_candy();
      test_deny_funds();
      test_deny_multihot();
      test_back_to_back();
      test_refund(90, 1'b0);
      test_refund(0, 1'b0);
      test_refund(75, 1'b1);
      test_refund(19, 1'b0);
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
